esfa_vector_fetcher: RTL

Fetches 64-bit test vectors from the synchronous test-vector block ROM and hands them, decoded, to the ESFA checker through a valid/ready handshake. It sits directly upstream of the checking stage that drives `ESFADesign`, and replaces ad-hoc address toggling with credit-based prefetch. Fetching stops at the end-of-program word. The block reports completion, vector count and ROM-overrun status.

---
 rtl/esfa_vector_fetcher.sv | 114 +++++++++++
 1 files changed

// File: rtl/esfa_vector_fetcher.sv
// Credit-based prefetcher: streams 64-bit test vectors from a one-cycle-latency ROM
// into a 2-entry FIFO and presents the decoded head entry over valid/ready.
//
// state   | meaning
// IDLE    | waiting for start
// FETCH   | issuing reads within credit, enqueuing returned vectors
// DRAIN   | end word seen or address range exhausted; emptying the FIFO
// DONE    | program complete; terminal until reset
module esfa_vector_fetcher #(
  parameter logic [31:0] ADDR_STEP = 32'd8,
  parameter logic [31:0] MAX_ADDR  = 32'h0000_FFF8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        rom_en,
  output logic [31:0] rom_addr,
  input  logic [63:0] rom_data,
  output logic        vec_valid,
  input  logic        vec_ready,
  output logic        vec_is_mutating,
  output logic        vec_exp_bool,
  output logic [7:0]  vec_handle,
  output logic [7:0]  vec_new_index,
  output logic [7:0]  vec_new_value,
  output logic [7:0]  vec_selector,
  output logic [7:0]  vec_exp_value,
  output logic        busy,
  output logic        done,
  output logic        overrun,
  output logic [15:0] vec_count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [41:0] fifo_mem [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;
  logic [1:0]  count_nxt;
  logic        outstanding;
  logic        push;
  logic        pop;
  logic        end_ret;
  logic        credit_ok;
  logic        want_issue;
  logic        addr_over;
  logic        overrun_hit;
  logic        unused_bits;

  assign vec_valid   = (count != 2'd0);
  assign pop         = vec_valid && vec_ready;
  assign end_ret     = outstanding && rom_data[2];
  assign push        = outstanding && !rom_data[2] && (state == S_FETCH);
  // Credit counts buffered words plus the read in flight, freed by a same-cycle pop.
  assign credit_ok   = ({1'b0, count} + {2'b00, outstanding}) < (3'd2 + {2'b00, pop});
  assign want_issue  = (state == S_FETCH) && credit_ok && !end_ret;
  assign addr_over   = rom_addr > MAX_ADDR;
  assign rom_en      = want_issue && !addr_over;
  assign overrun_hit = want_issue && addr_over;
  assign count_nxt   = count + {1'b0, push} - {1'b0, pop};
  assign unused_bits = ^{rom_data[63:48], rom_data[7:3]};

  assign {vec_exp_value, vec_selector, vec_new_value, vec_new_index,
          vec_handle, vec_exp_bool, vec_is_mutating} = fifo_mem[rd_ptr];

  assign busy = (state == S_FETCH) || (state == S_DRAIN);
  assign done = (state == S_DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_FETCH;
      S_FETCH: if (end_ret || overrun_hit) state_nxt = S_DRAIN;
      S_DRAIN: if ((count_nxt == 2'd0) && !outstanding) state_nxt = S_DONE;
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      count       <= 2'd0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      outstanding <= 1'b0;
      rom_addr    <= 32'd0;
      overrun     <= 1'b0;
      vec_count   <= 16'd0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
    end else begin
      state       <= state_nxt;
      count       <= count_nxt;
      outstanding <= rom_en;
      if (rom_en) rom_addr <= rom_addr + ADDR_STEP;
      if (overrun_hit) overrun <= 1'b1;
      if (push) begin
        fifo_mem[wr_ptr] <= {rom_data[47:8], rom_data[1:0]};
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
        if (vec_count != 16'hFFFF) vec_count <= vec_count + 16'd1;
      end
    end
  end

endmodule
